// File: rtl/llsc_reservation_monitor.sv
// Per-context LL/SC reservation monitor: one reservation (valid, granule address, age)
// per hardware context, with same-cycle SC verdict and forwarded next-state LLbit flags.
module llsc_reservation_monitor #(
  parameter int NUM_CTX  = 2,
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 0,
  localparam int CTX_W   = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CTX-1:0]  flush_i,
  input  logic                ll_valid_i,
  input  logic [CTX_W-1:0]    ll_ctx_i,
  input  logic [ADDR_W-1:0]   ll_addr_i,
  input  logic                sc_valid_i,
  input  logic [CTX_W-1:0]    sc_ctx_i,
  input  logic [ADDR_W-1:0]   sc_addr_i,
  output logic                sc_success_o,
  input  logic                st_valid_i,
  input  logic                st_ext_i,
  input  logic [CTX_W-1:0]    st_ctx_i,
  input  logic [ADDR_W-1:0]   st_addr_i,
  output logic [NUM_CTX-1:0]  llbit_o,
  input  logic [CTX_W-1:0]    lladdr_ctx_i,
  output logic [ADDR_W-1:0]   lladdr_o
);

  localparam int GW    = ADDR_W - GRAN_LSB;
  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NUM_CTX-1:0] valid;
  logic [GW-1:0]      gaddr [NUM_CTX];
  logic [AGE_W-1:0]   age   [NUM_CTX];

  logic [NUM_CTX-1:0] valid_nxt;
  logic [NUM_CTX-1:0] st_other;
  logic [NUM_CTX-1:0] kill;
  logic [NUM_CTX-1:0] ll_hit;
  logic [NUM_CTX-1:0] sc_hit;
  logic [NUM_CTX-1:0] expire;
  logic [NUM_CTX-1:0] age_inc;
  logic [GW-1:0]      ll_gran;
  logic [GW-1:0]      sc_gran;
  logic [GW-1:0]      st_gran;
  logic               st_src_ok;

  function automatic logic ctx_ok(input logic [CTX_W-1:0] c);
    return int'(c) < NUM_CTX;
  endfunction

  // Per-context kill/priority resolution, SC verdict and LLAddr readout mux.
  always_comb begin
    ll_gran      = ll_addr_i[ADDR_W-1:GRAN_LSB];
    sc_gran      = sc_addr_i[ADDR_W-1:GRAN_LSB];
    st_gran      = st_addr_i[ADDR_W-1:GRAN_LSB];
    // A local store from a nonexistent context is ignored rather than treated as foreign.
    st_src_ok    = st_valid_i & (st_ext_i | ctx_ok(st_ctx_i));
    sc_success_o = 1'b0;
    lladdr_o     = '0;
    valid_nxt    = '0;
    st_other     = '0;
    kill         = '0;
    ll_hit       = '0;
    sc_hit       = '0;
    expire       = '0;
    age_inc      = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      st_other[i] = st_src_ok & (st_ext_i | (st_ctx_i != CTX_W'(i)));
      kill[i]     = st_other[i] & (st_gran == gaddr[i]);
      ll_hit[i]   = ll_valid_i & (ll_ctx_i == CTX_W'(i));
      sc_hit[i]   = sc_valid_i & (sc_ctx_i == CTX_W'(i));
      expire[i]   = (TIMEOUT > 0) & valid[i] & (age[i] == AGE_LAST);
      if (rst) begin
        valid_nxt[i] = 1'b0;
      end else if (flush_i[i]) begin
        valid_nxt[i] = 1'b0;
      end else if (ll_hit[i]) begin
        valid_nxt[i] = ~(st_other[i] & (st_gran == ll_gran));
      end else if (sc_hit[i] | kill[i] | expire[i]) begin
        valid_nxt[i] = 1'b0;
      end else begin
        valid_nxt[i] = valid[i];
        age_inc[i]   = (TIMEOUT > 0) & valid[i];
      end
      sc_success_o = sc_success_o | (sc_hit[i] & valid[i] & (sc_gran == gaddr[i])
                                     & ~flush_i[i] & ~kill[i]);
      lladdr_o     = lladdr_o | ((lladdr_ctx_i == CTX_W'(i))
                                 ? (ADDR_W'(gaddr[i]) << GRAN_LSB) : '0);
    end
    llbit_o = valid_nxt;
  end

  // Reservation state; gaddr is kept after valid clears so LLAddr stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NUM_CTX; i++) begin
        gaddr[i] <= '0;
        age[i]   <= '0;
      end
    end else begin
      valid <= valid_nxt;
      for (int i = 0; i < NUM_CTX; i++) begin
        if (!flush_i[i] && ll_hit[i]) begin
          gaddr[i] <= ll_gran;
          age[i]   <= '0;
        end else if (age_inc[i]) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end

endmodule
